// File: rtl/reset_request_gen_if.sv
// Board-side signals of the reset request generator: push button and DCM lock in, DCM reset,
// reset request and fault out. Optional status outputs exist only when RSTGEN_STATUS_EN is defined.
interface reset_request_gen_if;
    logic       btn_n_i;
    logic       dcm_locked;
    logic       dcm_rst_o;
    logic       resetn_o;
    logic       fail_o;
`ifdef RSTGEN_STATUS_EN
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt_o;

    modport master (
        input  btn_n_i,
        input  dcm_locked,
        output dcm_rst_o,
        output resetn_o,
        output fail_o,
        output state_o,
        output lock_loss_cnt_o
    );

    modport slave (
        output btn_n_i,
        output dcm_locked,
        input  dcm_rst_o,
        input  resetn_o,
        input  fail_o,
        input  state_o,
        input  lock_loss_cnt_o
    );
`else
    modport master (
        input  btn_n_i,
        input  dcm_locked,
        output dcm_rst_o,
        output resetn_o,
        output fail_o
    );

    modport slave (
        output btn_n_i,
        output dcm_locked,
        input  dcm_rst_o,
        input  resetn_o,
        input  fail_o
    );
`endif
endinterface

// File: rtl/reset_request_gen.sv
// Board reset source: debounced button, DCM reset pulsing with lock retry/fault, stretched reset request.
// RSTGEN_STATUS_EN adds state_o and a saturating lock-loss counter.
module reset_request_gen #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int DCM_RST_CYCLES  = 4,
    parameter int LOCK_TIMEOUT    = 12000,
    parameter int HOLD_CYCLES     = 16,
    parameter int MAX_RETRIES     = 3
) (
    input logic               clk_i,
    input logic               rst_i,
    reset_request_gen_if.master bus
);
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_A   = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMR_MAX = (TMR_A > HOLD_CYCLES) ? TMR_A : HOLD_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int RET_W   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_DCM_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD      = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         btn_sync_q, btn_sync_d;
    logic [1:0]         lock_sync_q, lock_sync_d;
    logic               stable_q, stable_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [RET_W-1:0]   retries_q, retries_d;
    logic               dcm_rst_q, dcm_rst_d;
    logic               resetn_q, resetn_d;
    logic               fail_q, fail_d;
    logic               btn_s, lock_s, press, lock_loss;

    always_comb begin
        btn_sync_d  = {btn_sync_q[0], bus.btn_n_i};
        lock_sync_d = {lock_sync_q[0], bus.dcm_locked};
        btn_s       = btn_sync_q[1];
        lock_s      = lock_sync_q[1];

        // Counter only runs while the synced level disagrees with the accepted one.
        stable_d = stable_q;
        db_cnt_d = '0;
        press    = 1'b0;
        if (btn_s != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = btn_s;
                press    = stable_q & ~btn_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        state_d   = state_q;
        tmr_d     = tmr_q;
        retries_d = retries_q;
        lock_loss = 1'b0;
        case (state_q)
            S_DCM_RST: begin
                if (tmr_q == TMR_W'(DCM_RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_HOLD;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    retries_d = retries_q + 1'b1;
                    tmr_d     = '0;
                    state_d   = (int'(retries_q) + 1 == MAX_RETRIES) ? S_FAIL : S_DCM_RST;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!lock_s) begin
                    state_d   = S_DCM_RST;
                    tmr_d     = '0;
                    lock_loss = 1'b1;
                end else if (press) begin
                    tmr_d = '0;
                end else if (tmr_q == TMR_W'(HOLD_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    tmr_d     = '0;
                    retries_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d   = S_DCM_RST;
                    tmr_d     = '0;
                    retries_d = '0;
                    lock_loss = 1'b1;
                end else if (press) begin
                    state_d = S_HOLD;
                    tmr_d   = '0;
                end
            end
            S_FAIL: begin
                if (press) begin
                    state_d   = S_DCM_RST;
                    tmr_d     = '0;
                    retries_d = '0;
                end
            end
            default: begin
                state_d = S_DCM_RST;
                tmr_d   = '0;
            end
        endcase

        // Outputs registered from the next state so they change on the transition edge.
        dcm_rst_d = (state_d == S_DCM_RST);
        resetn_d  = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_DCM_RST;
            btn_sync_q  <= 2'b11;
            lock_sync_q <= 2'b00;
            stable_q    <= 1'b1;
            db_cnt_q    <= '0;
            tmr_q       <= '0;
            retries_q   <= '0;
            dcm_rst_q   <= 1'b1;
            resetn_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_sync_q  <= btn_sync_d;
            lock_sync_q <= lock_sync_d;
            stable_q    <= stable_d;
            db_cnt_q    <= db_cnt_d;
            tmr_q       <= tmr_d;
            retries_q   <= retries_d;
            dcm_rst_q   <= dcm_rst_d;
            resetn_q    <= resetn_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.dcm_rst_o = dcm_rst_q;
    assign bus.resetn_o  = resetn_q;
    assign bus.fail_o    = fail_q;

`ifdef RSTGEN_STATUS_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_loss && (loss_cnt_q != 8'hff)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.state_o         = state_q;
    assign bus.lock_loss_cnt_o = loss_cnt_q;
`else
    logic unused_lock_loss;
    assign unused_lock_loss = lock_loss;
`endif
endmodule
